// File: rtl/pipe_hazard_ctrl_if.sv
// Data-memory request/ready handshake between the hazard sequencer
// and the data-memory port.
interface pipe_hazard_ctrl_if;
   logic req;
   logic ready;

   modport master (output req, input ready);
   modport slave (input req, output ready);
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline registers.
// Optional event counters: define PIPE_HAZARD_CTRL_PERF_EN.
module pipe_hazard_ctrl #(
   parameter int MAX_WAIT = 16,
   parameter int CNT_W    = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic [4:0]       ex_rd,
   input  logic             ex_memread,
   input  logic             ex_redirect,
   input  logic             mem_access,
   pipe_hazard_ctrl_if.master dmem,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             id_ex_en,
   output logic             ex_mem_en,
   output logic             mem_wb_en,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             mem_wb_flush,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] perf_mem_stall,
   output logic [CNT_W-1:0] perf_lu_stall,
   output logic [CNT_W-1:0] perf_flush
);

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_t;

   localparam logic [7:0] LIM   = 8'(MAX_WAIT);
   localparam logic [7:0] LIM_M = 8'(MAX_WAIT - 1);

   state_t     state_q, state_d;
   logic [7:0] wcnt_q;
   logic       mstall;
   logic       lu;
   logic       hit1, hit2;

   assign mstall = mem_access & ~dmem.ready;
   assign hit1   = id_use_rs1 & (id_rs1 == ex_rd);
   assign hit2   = id_use_rs2 & (id_rs2 == ex_rd);
   assign lu     = ex_memread & (ex_rd != 5'd0) & (hit1 | hit2);

   always_ff @(posedge clk) begin
      if (reset) state_q <= RUN;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RUN:      if (mstall)     state_d = MEM_WAIT;
         MEM_WAIT: if (dmem.ready) state_d = RUN;
         default:  state_d = RUN;
      endcase
   end

   // Counter keeps running (saturated) after a timeout; no abort
   always_ff @(posedge clk) begin
      if (reset) begin
         wcnt_q      <= 8'd0;
         mem_timeout <= 1'b0;
      end else if (state_q == RUN) begin
         if (state_d == MEM_WAIT) wcnt_q <= 8'd0;
      end else begin
         if (wcnt_q != LIM)    wcnt_q      <= wcnt_q + 8'd1;
         if (wcnt_q >= LIM_M)  mem_timeout <= 1'b1;
      end
   end

   always_comb begin
      dmem.req     = mem_access & ~reset;
      pc_en        = 1'b1;
      if_id_en     = 1'b1;
      id_ex_en     = 1'b1;
      ex_mem_en    = 1'b1;
      mem_wb_en    = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      mem_wb_flush = 1'b0;
      if (reset) begin
         pc_en        = 1'b0;
         if_id_en     = 1'b0;
         id_ex_en     = 1'b0;
         ex_mem_en    = 1'b0;
         mem_wb_en    = 1'b0;
         if_id_flush  = 1'b1;
         id_ex_flush  = 1'b1;
         mem_wb_flush = 1'b1;
      end else if (mstall) begin
         // bubble into WB so the stalled MEM result is written once
         pc_en        = 1'b0;
         if_id_en     = 1'b0;
         id_ex_en     = 1'b0;
         ex_mem_en    = 1'b0;
         mem_wb_flush = 1'b1;
      end else if (ex_redirect) begin
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else if (lu) begin
         pc_en       = 1'b0;
         if_id_en    = 1'b0;
         id_ex_flush = 1'b1;
      end
   end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
   logic [CNT_W-1:0] ms_q, lu_q, fl_q;
   logic             lu_ev, fl_ev;

   assign lu_ev = lu & ~mstall & ~ex_redirect;
   assign fl_ev = ex_redirect & ~mstall;

   always_ff @(posedge clk) begin
      if (reset) begin
         ms_q <= '0;
         lu_q <= '0;
         fl_q <= '0;
      end else begin
         if (mstall) ms_q <= ms_q + 1'b1;
         if (lu_ev)  lu_q <= lu_q + 1'b1;
         if (fl_ev)  fl_q <= fl_q + 1'b1;
      end
   end

   assign perf_mem_stall = ms_q;
   assign perf_lu_stall  = lu_q;
   assign perf_flush     = fl_q;
`else
   assign perf_mem_stall = '0;
   assign perf_lu_stall  = '0;
   assign perf_flush     = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl.
// Control vector: {pc,if_id,id_ex,ex_mem,mem_wb en, if_id,id_ex,mem_wb flush}.
module tb_pipe_hazard_ctrl;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
   localparam int PERF = 1;
`else
   localparam int PERF = 0;
`endif

   localparam logic [7:0] C_RST  = 8'b00000_111;
   localparam logic [7:0] C_RUN  = 8'b11111_000;
   localparam logic [7:0] C_LU   = 8'b00111_010;
   localparam logic [7:0] C_MST  = 8'b00001_001;
   localparam logic [7:0] C_REDR = 8'b11111_110;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  id_rs1, id_rs2, ex_rd;
   logic        id_use_rs1, id_use_rs2;
   logic        ex_memread, ex_redirect, mem_access;
   logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
   logic        if_id_flush, id_ex_flush, mem_wb_flush;
   logic        mem_timeout;
   logic [31:0] perf_mem_stall, perf_lu_stall, perf_flush;

   int checks = 0;
   int errors = 0;

   pipe_hazard_ctrl_if dmem ();

   pipe_hazard_ctrl #(.MAX_WAIT(16), .CNT_W(32)) dut (
      .clk           (clk),
      .reset         (reset),
      .id_rs1        (id_rs1),
      .id_rs2        (id_rs2),
      .id_use_rs1    (id_use_rs1),
      .id_use_rs2    (id_use_rs2),
      .ex_rd         (ex_rd),
      .ex_memread    (ex_memread),
      .ex_redirect   (ex_redirect),
      .mem_access    (mem_access),
      .dmem          (dmem.master),
      .pc_en         (pc_en),
      .if_id_en      (if_id_en),
      .id_ex_en      (id_ex_en),
      .ex_mem_en     (ex_mem_en),
      .mem_wb_en     (mem_wb_en),
      .if_id_flush   (if_id_flush),
      .id_ex_flush   (id_ex_flush),
      .mem_wb_flush  (mem_wb_flush),
      .mem_timeout   (mem_timeout),
      .perf_mem_stall(perf_mem_stall),
      .perf_lu_stall (perf_lu_stall),
      .perf_flush    (perf_flush)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] ctl();
      return {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
              if_id_flush, id_ex_flush, mem_wb_flush};
   endfunction

   function automatic logic [31:0] pexp(input int n);
      return (PERF != 0) ? 32'(n) : 32'd0;
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic idle();
      id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
      id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
      ex_memread = 1'b0; ex_redirect = 1'b0; mem_access = 1'b0;
      dmem.ready = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      idle();
      mem_access = 1'b1;
      tick();
      #1;
      chk("rst_ctl", 32'(ctl()), 32'(C_RST));
      chk("rst_req", 32'(dmem.req), 32'd0);
      tick();
      chk("rst_state", 32'(dut.state_q), 32'd0);
      chk("rst_tmo", 32'(mem_timeout), 32'd0);
      chk("rst_pms", perf_mem_stall, 32'd0);

      reset = 1'b0;
      idle();
      #1;
      chk("idle_ctl", 32'(ctl()), 32'(C_RUN));
      tick();

      // load-use on rs1
      ex_memread = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
      #1;
      chk("lu_rs1", 32'(ctl()), 32'(C_LU));
      tick();
      idle();
      #1;
      chk("lu_after", 32'(ctl()), 32'(C_RUN));
      chk("lu_cnt1", perf_lu_stall, pexp(1));

      // ex_rd = x0 never stalls
      ex_memread = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
      #1;
      chk("lu_x0", 32'(ctl()), 32'(C_RUN));
      tick();

      // rs2 match only counts when rs2 is used
      idle();
      ex_memread = 1'b1; ex_rd = 5'd9; id_rs2 = 5'd9;
      #1;
      chk("lu_rs2_unused", 32'(ctl()), 32'(C_RUN));
      id_use_rs2 = 1'b1;
      #1;
      chk("lu_rs2", 32'(ctl()), 32'(C_LU));
      tick();
      idle();
      #1;
      chk("lu_cnt2", perf_lu_stall, pexp(2));

      // 3-wait access
      mem_access = 1'b1; dmem.ready = 1'b0;
      #1;
      chk("mw_req", 32'(dmem.req), 32'd1);
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("mw_ctl%0d", i), 32'(ctl()), 32'(C_MST));
         tick();
         chk($sformatf("mw_st%0d", i), 32'(dut.state_q), 32'd1);
      end
      dmem.ready = 1'b1;
      #1;
      chk("mw_adv", 32'(ctl()), 32'(C_RUN));
      tick();
      chk("mw_run", 32'(dut.state_q), 32'd0);
      chk("mw_cnt", perf_mem_stall, pexp(3));
      idle();

      // redirect beats load-use
      ex_memread = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 1'b1;
      ex_redirect = 1'b1;
      #1;
      chk("redr_lu", 32'(ctl()), 32'(C_REDR));
      tick();
      chk("redr_fl", perf_flush, pexp(1));
      chk("redr_lu_cnt", perf_lu_stall, pexp(2));

      // redirect held while memory stalls
      idle();
      ex_redirect = 1'b1; mem_access = 1'b1;
      #1;
      chk("redr_mst", 32'(ctl()), 32'(C_MST));
      tick();
      dmem.ready = 1'b1;
      #1;
      chk("redr_rel", 32'(ctl()), 32'(C_REDR));
      tick();
      chk("redr_fl2", perf_flush, pexp(2));
      chk("redr_ms", perf_mem_stall, pexp(4));

      // timeout: entry edge clears count, then 16 MEM_WAIT edges
      idle();
      mem_access = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         tick();
         chk($sformatf("tmo_%0d", k), 32'(mem_timeout),
             (k >= 17) ? 32'd1 : 32'd0);
      end
      dmem.ready = 1'b1;
      tick();
      chk("tmo_sticky", 32'(mem_timeout), 32'd1);
      chk("tmo_ms", perf_mem_stall, pexp(24));
      chk("tmo_st", 32'(dut.state_q), 32'd0);

      // reset in the middle of a wait
      dmem.ready = 1'b0;
      tick();
      chk("mrst_pre", 32'(dut.state_q), 32'd1);
      reset = 1'b1;
      #1;
      chk("mrst_ctl", 32'(ctl()), 32'(C_RST));
      chk("mrst_req", 32'(dmem.req), 32'd0);
      tick();
      chk("mrst_st", 32'(dut.state_q), 32'd0);
      chk("mrst_tmo", 32'(mem_timeout), 32'd0);
      chk("mrst_ms", perf_mem_stall, 32'd0);
      chk("mrst_lu", perf_lu_stall, 32'd0);
      chk("mrst_fl", perf_flush, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
